instr_mem_loader: RTL and testbench

Byte-stream controller that owns the instruction-fetch debug port and the CPU valid line. In LOAD mode it assembles incoming bytes from the debug UART into 32-bit instructions and writes them sequentially into instruction memory through port B. In RUN or STEP mode it gates the pipeline clock-enable (i_valid of the fetch/pipeline stages) and counts executed cycles until the CPU reports halt.

---
 rtl/instr_mem_loader.sv | 189 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Debug-UART byte-stream controller: loads 32-bit words into instruction memory
// (LOAD) and gates the pipeline enable while counting cycles (RUN / STEP).
module instr_mem_loader #(
    parameter int                NB_INSTR  = 32,
    parameter int                NB_BYTE   = 8,
    parameter int                NB_ADDR   = 16,
    parameter int                N_ADDR    = 2048,
    parameter int                NB_CYC    = 32,
    parameter logic [NB_INSTR-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_cpu_halt,
    output logic [NB_ADDR-1:0]  o_instrmem_addr,
    output logic [NB_INSTR-1:0] o_instrmem_data,
    output logic [3:0]          o_instrmem_we,
    output logic                o_instrmem_re,
    output logic                o_cpu_valid,
    output logic [NB_CYC-1:0]   o_cycle_count,
    output logic [NB_ADDR-1:0]  o_word_count,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_STEP} state_t;

    localparam int NB_SHIFT = NB_INSTR - NB_BYTE;

    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_ABORT = NB_BYTE'(8'h58);
    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_ADDR - 1);

    state_t                state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [NB_SHIFT-1:0]   shift_q, shift_d;
    logic [NB_INSTR-1:0]   data_q, data_d;
    logic                  we_q, we_d;
    logic [NB_ADDR-1:0]    addr_q, addr_d;
    logic [NB_ADDR-1:0]    word_count_q, word_count_d;
    logic [NB_CYC-1:0]     cycle_q, cycle_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  write_last;

    // NOTE: reset is synchronous, so it sits inside the clocked branch; all state uses <=.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            word_count_q <= '0;
            cycle_q      <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            cycle_q      <= cycle_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // The word being written this cycle ends the load (halt word or last address).
    assign write_last = we_q && ((data_q == HALT_WORD) || (addr_q == LAST_ADDR));

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path infers a latch.
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        data_d       = data_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        cycle_d      = cycle_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        error_d      = error_q;

        if (valid_q && (cycle_q != '1)) begin
            cycle_d = cycle_q + NB_CYC'(1);
        end

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                if (i_rx_valid) begin
                    error_d = 1'b0;
                    case (i_rx_data)
                        CMD_LOAD: begin
                            state_d      = ST_LOAD;
                            addr_d       = '0;
                            word_count_d = '0;
                            byte_idx_d   = '0;
                        end
                        CMD_RUN: begin
                            state_d = ST_RUN;
                            cycle_d = '0;
                        end
                        CMD_STEP: begin
                            state_d = ST_STEP;
                            cycle_d = '0;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end

            ST_LOAD: begin
                if (we_q) begin
                    addr_d       = (addr_q == LAST_ADDR) ? addr_q : addr_q + NB_ADDR'(1);
                    word_count_d = word_count_q + NB_ADDR'(1);
                    if (write_last) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        if (data_q != HALT_WORD) begin
                            error_d = 1'b1;
                        end
                    end
                end
                // Byte collection overlaps the write cycle unless this write ends the load.
                if (i_rx_valid && !write_last) begin
                    if (byte_idx_q == 2'd3) begin
                        data_d     = {shift_q, i_rx_data};
                        we_d       = 1'b1;
                        byte_idx_d = '0;
                    end else begin
                        shift_d    = {shift_q[NB_SHIFT-NB_BYTE-1:0], i_rx_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end

            ST_RUN: begin
                if (i_cpu_halt || (i_rx_valid && (i_rx_data == CMD_ABORT))) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end

            ST_STEP: begin
                if (valid_q || i_cpu_halt) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign o_instrmem_addr = addr_q;
    assign o_instrmem_data = data_q;
    assign o_instrmem_we   = {4{we_q}};
    assign o_instrmem_re   = 1'b0;
    assign o_cpu_valid     = valid_q;
    assign o_cycle_count   = cycle_q;
    assign o_word_count    = word_count_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_done          = done_q;
    assign o_error         = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load, overflow, run/halt, step, abort and reset cases.
module tb_instr_mem_loader;

    localparam int N_ADDR = 2048;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        i_cpu_halt;
    logic [15:0] o_instrmem_addr;
    logic [31:0] o_instrmem_data;
    logic [3:0]  o_instrmem_we;
    logic        o_instrmem_re;
    logic        o_cpu_valid;
    logic [31:0] o_cycle_count;
    logic [15:0] o_word_count;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    always #5 i_clock = ~i_clock;

    instr_mem_loader dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_rx_data       (i_rx_data),
        .i_rx_valid      (i_rx_valid),
        .i_cpu_halt      (i_cpu_halt),
        .o_instrmem_addr (o_instrmem_addr),
        .o_instrmem_data (o_instrmem_data),
        .o_instrmem_we   (o_instrmem_we),
        .o_instrmem_re   (o_instrmem_re),
        .o_cpu_valid     (o_cpu_valid),
        .o_cycle_count   (o_cycle_count),
        .o_word_count    (o_word_count),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_error         (o_error)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor, sampled 1 time unit after each rising edge.
    int          wr_cnt    = 0;
    int          done_cnt  = 0;
    int          valid_cnt = 0;
    int          bad_cnt   = 0;
    logic [15:0] wr_addr [0:4095];
    logic [31:0] wr_data [0:4095];

    always @(posedge i_clock) begin
        #1;
        if (o_instrmem_we != 4'h0) begin
            if (wr_cnt < 4096) begin
                wr_addr[wr_cnt] = o_instrmem_addr;
                wr_data[wr_cnt] = o_instrmem_data;
            end
            wr_cnt++;
            if (o_instrmem_we != 4'hF || int'(o_instrmem_addr) >= N_ADDR) bad_cnt++;
            if (o_cpu_valid) bad_cnt++;
        end
        if (o_done)        done_cnt++;
        if (o_cpu_valid)   valid_cnt++;
        if (o_instrmem_re) bad_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    // Called at a negedge; strobes one byte for one cycle and returns at the next negedge.
    task automatic send(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clock);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"},  32'(o_instrmem_addr), 32'h0);
        check({tag, "_data"},  o_instrmem_data,      32'h0);
        check({tag, "_we"},    32'(o_instrmem_we),   32'h0);
        check({tag, "_valid"}, 32'(o_cpu_valid),     32'h0);
        check({tag, "_cyc"},   o_cycle_count,        32'h0);
        check({tag, "_wc"},    32'(o_word_count),    32'h0);
        check({tag, "_busy"},  32'(o_busy),          32'h0);
        check({tag, "_done"},  32'(o_done),          32'h0);
        check({tag, "_err"},   32'(o_error),         32'h0);
    endtask

    int w0, d0, v0, n, errs;

    initial begin
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        i_cpu_halt = 1'b0;
        idle(3);
        check_zero("reset");
        i_reset = 1'b0;
        idle(1);

        // Short program terminated by the halt word.
        w0 = wr_cnt; d0 = done_cnt;
        send(8'h4C);
        send_word(32'h00000020);
        send_word(32'h8C010004);
        send_word(32'hFFFFFFFF);
        idle(3);
        check("load_wr_cnt",  32'(wr_cnt - w0), 32'd3);
        check("load_addr0",   32'(wr_addr[w0]),   32'd0);
        check("load_data0",   wr_data[w0],        32'h00000020);
        check("load_addr1",   32'(wr_addr[w0+1]), 32'd1);
        check("load_data1",   wr_data[w0+1],      32'h8C010004);
        check("load_addr2",   32'(wr_addr[w0+2]), 32'd2);
        check("load_data2",   wr_data[w0+2],      32'hFFFFFFFF);
        check("load_wc",      32'(o_word_count),  32'd3);
        check("load_done",    32'(done_cnt - d0), 32'd1);
        check("load_busy",    32'(o_busy),        32'd0);
        check("load_err",     32'(o_error),       32'd0);

        // Fill all of memory without a halt word: overflow.
        w0 = wr_cnt; d0 = done_cnt;
        send(8'h4C);
        for (int i = 0; i < N_ADDR; i++) begin
            send_word(32'h10000000 + 32'(i));
            if (i == 10) check("ovf_busy", 32'(o_busy), 32'd1);
        end
        idle(4);
        check("ovf_wr_cnt", 32'(wr_cnt - w0), 32'd2048);
        errs = 0;
        for (int i = 0; i < N_ADDR; i++) begin
            if (wr_addr[w0+i] !== 16'(i) || wr_data[w0+i] !== 32'h10000000 + 32'(i)) errs++;
        end
        check("ovf_seq_errs", 32'(errs),                  32'd0);
        check("ovf_last_addr", 32'(wr_addr[w0+N_ADDR-1]), 32'd2047);
        check("ovf_err",      32'(o_error),               32'd1);
        check("ovf_done",     32'(done_cnt - d0),         32'd1);
        check("ovf_wc",       32'(o_word_count),          32'd2048);
        check("ovf_busy_end", 32'(o_busy),                32'd0);

        // RUN; halt is sampled at the edge closing the 10th valid cycle, which still counts.
        d0 = done_cnt; v0 = valid_cnt;
        send(8'h52);
        check("run_clr_err",  32'(o_error),     32'd0);
        check("run_entry_v",  32'(o_cpu_valid), 32'd0);
        n = 0;
        while (!o_cpu_valid && n < 20) begin idle(1); n++; end
        check("run_start_lat", 32'(n), 32'd1);
        idle(9);
        i_cpu_halt = 1'b1;
        idle(1);
        i_cpu_halt = 1'b0;
        check("run_halt_v",   32'(o_cpu_valid),   32'd0);
        check("run_halt_done", 32'(o_done),       32'd1);
        check("run_halt_busy", 32'(o_busy),       32'd0);
        check("run_cyc",      o_cycle_count,      32'd10);
        idle(2);
        check("run_valid_cnt", 32'(valid_cnt - v0), 32'd10);
        check("run_done_cnt", 32'(done_cnt - d0),   32'd1);

        // Three single steps.
        for (int s = 0; s < 3; s++) begin
            d0 = done_cnt; v0 = valid_cnt;
            send(8'h53);
            idle(3);
            check("step_valid", 32'(valid_cnt - v0), 32'd1);
            check("step_done",  32'(done_cnt - d0),  32'd1);
            check("step_cyc",   o_cycle_count,       32'd1);
            check("step_busy",  32'(o_busy),         32'd0);
        end

        // Step with the CPU already halted: no valid pulse, done still pulses.
        d0 = done_cnt; v0 = valid_cnt;
        i_cpu_halt = 1'b1;
        send(8'h53);
        idle(3);
        i_cpu_halt = 1'b0;
        check("steph_valid", 32'(valid_cnt - v0), 32'd0);
        check("steph_done",  32'(done_cnt - d0),  32'd1);
        check("steph_cyc",   o_cycle_count,       32'd0);

        // Unknown command in IDLE.
        send(8'h51);
        idle(1);
        check("unk_err",  32'(o_error), 32'd1);
        check("unk_busy", 32'(o_busy),  32'd0);

        // RUN, ignored byte, then abort.
        send(8'h52);
        check("abort_clr_err", 32'(o_error), 32'd0);
        idle(2);
        send(8'h41);
        check("ign_busy",  32'(o_busy),      32'd1);
        check("ign_valid", 32'(o_cpu_valid), 32'd1);
        send(8'h58);
        check("abort_valid", 32'(o_cpu_valid), 32'd0);
        check("abort_done",  32'(o_done),      32'd1);
        check("abort_busy",  32'(o_busy),      32'd0);
        check("abort_cyc",   o_cycle_count,    32'd3);

        // Reset in the middle of the second word of a load.
        w0 = wr_cnt;
        send(8'h4C);
        send_word(32'h11223344);
        send(8'hAA);
        send(8'hBB);
        i_reset = 1'b1;
        idle(1);
        check_zero("midrst");
        idle(1);
        i_reset = 1'b0;
        check("midrst_wr_cnt", 32'(wr_cnt - w0), 32'd1);

        w0 = wr_cnt;
        send(8'h4C);
        send_word(32'hDEADBEEF);
        send_word(32'hFFFFFFFF);
        idle(3);
        check("reload_wr_cnt", 32'(wr_cnt - w0),    32'd2);
        check("reload_addr0",  32'(wr_addr[w0]),    32'd0);
        check("reload_data0",  wr_data[w0],         32'hDEADBEEF);
        check("reload_addr1",  32'(wr_addr[w0+1]),  32'd1);
        check("reload_data1",  wr_data[w0+1],       32'hFFFFFFFF);
        check("reload_wc",     32'(o_word_count),   32'd2);

        check("protocol_violations", 32'(bad_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
